// File: rtl/lcd_sequencer.sv
// rtl/lcd_sequencer.sv - HD44780 power-up, init and filter status line writer
// Every byte goes through SETUP, PULSE, HOLD and WAIT; the line is rewritten when filter_type settles on a new value.
module lcd_sequencer #(
  parameter int POWERUP_CYCLES    = 750000,
  parameter int SETUP_CYCLES      = 3,
  parameter int EN_HIGH_CYCLES    = 25,
  parameter int CMD_WAIT_CYCLES   = 2500,
  parameter int CLEAR_WAIT_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] filter_type,
  output logic [7:0] LCD_DATA,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_ON,
  output logic       LCD_BLON,
  output logic       busy
);

  localparam int CW = $clog2(POWERUP_CYCLES + SETUP_CYCLES + EN_HIGH_CYCLES +
                             CMD_WAIT_CYCLES + CLEAR_WAIT_CYCLES + 1);

  localparam logic [CW-1:0] PU_LAST    = CW'(POWERUP_CYCLES - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] EN_LAST    = CW'(EN_HIGH_CYCLES - 1);
  localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] CLR_LAST   = CW'(CLEAR_WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_POWERUP, S_INIT, S_LOAD, S_ADDR, S_CHARS, S_DONE, S_IDLE
  } state_t;

  typedef enum logic [1:0] {P_SETUP, P_PULSE, P_HOLD, P_WAIT} phase_t;

  state_t        state, next_state;
  phase_t        phase, next_phase;
  logic [CW-1:0] cnt, next_cnt;
  logic [3:0]    idx, next_idx;
  logic [1:0]    shown_type, next_shown;
  logic          pending, next_pending;
  logic [7:0]    next_data;
  logic          next_rs, next_en;
  logic [CW-1:0] wait_last;
  logic          byte_done;

  function automatic logic [7:0] init_byte(input logic [1:0] i);
    case (i)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h01;
      default: init_byte = 8'h06;
    endcase
  endfunction

  // Character 0 sits in the most significant byte of the packed string.
  function automatic logic [7:0] char_byte(input logic [1:0] t, input logic [3:0] i);
    logic [127:0] s;
    logic [3:0]   j;
    case (t)
      2'b00:   s = "FILTER: NONE    ";
      2'b01:   s = "FILTER: BLUR    ";
      2'b10:   s = "FILTER: EDGE    ";
      default: s = "FILTER: INVERT  ";
    endcase
    j = 4'd15 - i;
    char_byte = s[{j, 3'b000} +: 8];
  endfunction

  assign LCD_RW = 1'b0;
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_POWERUP;
      phase      <= P_SETUP;
      cnt        <= '0;
      idx        <= '0;
      shown_type <= 2'b00;
      pending    <= 1'b0;
      LCD_DATA   <= 8'h00;
      LCD_RS     <= 1'b0;
      LCD_EN     <= 1'b0;
      LCD_ON     <= 1'b0;
      LCD_BLON   <= 1'b0;
    end else begin
      state      <= next_state;
      phase      <= next_phase;
      cnt        <= next_cnt;
      idx        <= next_idx;
      shown_type <= next_shown;
      pending    <= next_pending;
      LCD_DATA   <= next_data;
      LCD_RS     <= next_rs;
      LCD_EN     <= next_en;
      LCD_ON     <= 1'b1;
      LCD_BLON   <= 1'b1;
    end
  end

  always_comb begin
    next_state   = state;
    next_phase   = phase;
    next_cnt     = cnt;
    next_idx     = idx;
    next_shown   = shown_type;
    next_pending = pending;
    next_data    = LCD_DATA;
    next_rs      = LCD_RS;
    next_en      = LCD_EN;
    byte_done    = 1'b0;
    wait_last    = (LCD_DATA == 8'h01 && !LCD_RS) ? CLR_LAST : CMD_LAST;

    // The rewrite decision is deferred to DONE; IDLE reacts to a change directly.
    if (state != S_IDLE && state != S_LOAD && filter_type != shown_type)
      next_pending = 1'b1;

    case (state)
      S_POWERUP: begin
        if (cnt == PU_LAST) begin
          next_state = S_INIT;
          next_phase = P_SETUP;
          next_cnt   = '0;
          next_idx   = '0;
          next_data  = init_byte(2'd0);
          next_rs    = 1'b0;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      S_INIT, S_ADDR, S_CHARS: begin
        case (phase)
          P_SETUP: begin
            if (cnt == SETUP_LAST) begin
              next_phase = P_PULSE;
              next_cnt   = '0;
              next_en    = 1'b1;
            end else begin
              next_cnt = cnt + 1'b1;
            end
          end
          P_PULSE: begin
            if (cnt == EN_LAST) begin
              next_phase = P_HOLD;
              next_cnt   = '0;
              next_en    = 1'b0;
            end else begin
              next_cnt = cnt + 1'b1;
            end
          end
          P_HOLD: begin
            if (cnt == SETUP_LAST) begin
              next_phase = P_WAIT;
              next_cnt   = '0;
            end else begin
              next_cnt = cnt + 1'b1;
            end
          end
          P_WAIT: begin
            if (cnt == wait_last) byte_done = 1'b1;
            else next_cnt = cnt + 1'b1;
          end
        endcase
      end
      S_LOAD: begin
        next_shown   = filter_type;
        next_pending = 1'b0;
        next_state   = S_ADDR;
        next_phase   = P_SETUP;
        next_cnt     = '0;
        next_data    = 8'h80;
        next_rs      = 1'b0;
      end
      S_DONE: begin
        next_state = (pending && filter_type != shown_type) ? S_LOAD : S_IDLE;
      end
      S_IDLE: begin
        if (filter_type != shown_type) next_state = S_LOAD;
      end
      default: next_state = S_POWERUP;
    endcase

    // Next byte is loaded on entry to SETUP so data never moves during EN or HOLD.
    if (byte_done) begin
      next_cnt   = '0;
      next_phase = P_SETUP;
      case (state)
        S_INIT: begin
          if (idx == 4'd3) begin
            next_state = S_LOAD;
          end else begin
            next_idx  = idx + 4'd1;
            next_data = init_byte(idx[1:0] + 2'd1);
          end
        end
        S_ADDR: begin
          next_state = S_CHARS;
          next_idx   = 4'd0;
          next_data  = char_byte(shown_type, 4'd0);
          next_rs    = 1'b1;
        end
        default: begin
          if (idx == 4'd15) begin
            next_state = S_DONE;
          end else begin
            next_idx  = idx + 4'd1;
            next_data = char_byte(shown_type, idx + 4'd1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb/tb_lcd_sequencer.sv - scoreboard bench for lcd_sequencer
// Driver pushes expected {RS,DATA} bytes; the monitor pops one per EN falling edge and checks timing.
module tb_lcd_sequencer;

  localparam int PU = 10;
  localparam int SU = 1;
  localparam int EH = 2;
  localparam int CM = 3;
  localparam int CL = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] filter_type = 2'b00;
  logic [7:0] LCD_DATA;
  logic       LCD_EN, LCD_RS, LCD_RW, LCD_ON, LCD_BLON, busy;

  lcd_sequencer #(
    .POWERUP_CYCLES(PU), .SETUP_CYCLES(SU), .EN_HIGH_CYCLES(EH),
    .CMD_WAIT_CYCLES(CM), .CLEAR_WAIT_CYCLES(CL)
  ) dut (
    .clk(clk), .reset(reset), .filter_type(filter_type),
    .LCD_DATA(LCD_DATA), .LCD_EN(LCD_EN), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .LCD_ON(LCD_ON), .LCD_BLON(LCD_BLON), .busy(busy)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [8:0] exp_q[$];
  int         pulse_count = 0;

  logic       mon_prev_en = 1'b0;
  logic       mon_first = 1'b1;
  logic       mon_last_clear = 1'b0;
  logic [7:0] mon_held = 8'h00;
  logic       mon_held_rs = 1'b0;
  int         mon_hi = 0;
  int         mon_lo = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic string status_text(input logic [1:0] t);
    case (t)
      2'b00:   return "FILTER: NONE";
      2'b01:   return "FILTER: BLUR";
      2'b10:   return "FILTER: EDGE";
      default: return "FILTER: INVERT";
    endcase
  endfunction

  task automatic expect_string(input logic [1:0] t);
    string s;
    s = status_text(t);
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++)
      exp_q.push_back({1'b1, (i < s.len()) ? 8'(s[i]) : 8'h20});
  endtask

  task automatic expect_powerup(input logic [1:0] t);
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
    expect_string(t);
  endtask

  initial begin : monitor
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_prev_en = 1'b0;
        mon_first   = 1'b1;
        mon_hi      = 0;
        mon_lo      = 0;
      end else begin
        if (LCD_EN) begin
          if (!mon_prev_en) begin
            if (!mon_first)
              check("en_low_gap_ok", 32'(mon_lo >= (mon_last_clear ? CL + 2*SU : CM + 2*SU)), 1);
            mon_held    = LCD_DATA;
            mon_held_rs = LCD_RS;
            mon_hi      = 0;
          end else begin
            check("data_stable_en_high", {LCD_RS, LCD_DATA}, {mon_held_rs, mon_held});
          end
          mon_hi++;
        end else begin
          if (mon_prev_en) begin
            check("en_high_width", mon_hi, EH);
            check("data_stable_hold", {LCD_RS, LCD_DATA}, {mon_held_rs, mon_held});
            check("rw_on_blon", {LCD_RW, LCD_ON, LCD_BLON}, 3'b011);
            vectors++;
            if (exp_q.size() == 0) begin
              miscompares++;
              $display("FAIL unexpected_byte: got rs=%0b data=%02h, expected no pulse", LCD_RS, LCD_DATA);
            end else begin
              e = exp_q.pop_front();
              if ({LCD_RS, LCD_DATA} !== e) begin
                miscompares++;
                $display("FAIL byte: got rs=%0b data=%02h, expected rs=%0b data=%02h",
                         LCD_RS, LCD_DATA, e[8], e[7:0]);
              end
            end
            mon_last_clear = (LCD_DATA == 8'h01) && !LCD_RS;
            mon_first      = 1'b0;
            mon_lo         = 0;
            pulse_count++;
          end
          mon_lo++;
        end
        mon_prev_en = LCD_EN;
      end
    end
  end

  task automatic set_filter(input logic [1:0] v);
    @(posedge clk);
    #2 filter_type = v;
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (busy !== 1'b1 && n < 3) begin
      @(negedge clk);
      n++;
    end
    check({name, "_busy_rise"}, busy, 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_busy_fall"}, busy, 0);
  endtask

  task automatic wait_pulses(input string name, input int target);
    int n = 0;
    while (pulse_count < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_pulse_reached"}, 32'(pulse_count >= target), 1);
  endtask

  initial begin : watchdog
    #500000;
    miscompares++;
    $display("FAIL watchdog: simulation did not complete, expected completion before time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : driver
    logic [1:0] shown_m, v, f;
    int base, k1, k2;

    reset = 1'b1;
    filter_type = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {LCD_DATA, LCD_EN, LCD_RS, LCD_RW, LCD_ON, LCD_BLON, busy},
          {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});

    expect_powerup(2'b00);
    base = pulse_count;
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("on_after_release", {LCD_ON, LCD_BLON, LCD_RW, busy}, 4'b1101);
    wait_idle("powerup");
    check("powerup_pulses", pulse_count - base, 21);
    check("powerup_queue", exp_q.size(), 0);
    shown_m = 2'b00;

    set_filter(2'b10);
    expect_string(2'b10);
    shown_m = 2'b10;
    base = pulse_count;
    wait_busy("edge");
    wait_idle("edge");
    check("edge_pulses", pulse_count - base, 17);
    check("edge_queue", exp_q.size(), 0);

    set_filter(2'b01);
    expect_string(2'b01);
    base = pulse_count;
    wait_busy("blur");
    wait_pulses("blur_idx5", base + 6);
    set_filter(2'b11);
    expect_string(2'b11);
    shown_m = 2'b11;
    wait_idle("blur_invert");
    check("blur_invert_pulses", pulse_count - base, 34);
    check("blur_invert_queue", exp_q.size(), 0);

    set_filter(2'b00);
    expect_string(2'b00);
    shown_m = 2'b00;
    base = pulse_count;
    wait_busy("toggle");
    wait_pulses("toggle_away", base + 5);
    set_filter(2'b01);
    wait_pulses("toggle_back", base + 10);
    set_filter(2'b00);
    wait_idle("toggle");
    repeat (10) @(negedge clk);
    check("toggle_pulses", pulse_count - base, 17);
    check("toggle_stays_idle", busy, 0);
    check("toggle_queue", exp_q.size(), 0);

    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        v = 2'($urandom_range(0, 3));
        base = pulse_count;
        set_filter(v);
        if (v != shown_m) begin
          expect_string(v);
          shown_m = v;
          wait_busy("rnd_idle");
          wait_idle("rnd_idle");
        end else begin
          repeat (5) @(negedge clk);
          check("rnd_same_no_rewrite", {busy, 32'(pulse_count - base) == 0}, 2'b01);
        end
      end else begin
        v = shown_m ^ 2'($urandom_range(1, 3));
        set_filter(v);
        expect_string(v);
        shown_m = v;
        base = pulse_count;
        wait_busy("rnd_mid");
        k1 = $urandom_range(2, 12);
        wait_pulses("rnd_k1", base + k1);
        f = 2'($urandom_range(0, 3));
        set_filter(f);
        if ($urandom_range(0, 1) == 1) begin
          k2 = $urandom_range(k1 + 1, 15);
          wait_pulses("rnd_k2", base + k2);
          f = 2'($urandom_range(0, 3));
          set_filter(f);
        end
        if (f != shown_m) begin
          expect_string(f);
          shown_m = f;
        end
        wait_idle("rnd_mid");
      end
      check("rnd_queue", exp_q.size(), 0);
    end

    set_filter(shown_m ^ 2'b01);
    wait_busy("midreset");
    begin
      int n = 0;
      while (LCD_EN !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    check("midreset_en_seen", LCD_EN, 1);
    #1 reset = 1'b1;
    #1 check("midreset_outputs", {LCD_EN, LCD_ON, LCD_BLON, busy}, 4'b0001);
    exp_q.delete();
    filter_type = 2'b00;
    repeat (2) @(posedge clk);
    expect_powerup(2'b00);
    base = pulse_count;
    #2 reset = 1'b0;
    wait_idle("repowerup");
    check("repowerup_pulses", pulse_count - base, 21);
    check("repowerup_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
